// File: rtl/phase_enable_sequencer.sv
// Phase-enable sequencer: locks to the phase detector, then rotates a one-hot,
// gap-separated enable across NUM_PHASES power-clock phases. Optional macro: PHASE_RESYNC_EN.
module phase_enable_sequencer #(
  parameter int NUM_PHASES   = 4,
  parameter int PHASE_CYCLES = 4,
  parameter int LOCK_EDGES   = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          phase_in,
  output logic [NUM_PHASES-1:0]         en,
  output logic [NUM_PHASES-1:0]         en_bar,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          locked,
  output logic                          busy,
  output logic                          lock_err
);

  localparam int IDX_W  = $clog2(NUM_PHASES);
  localparam int SLOT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int EC_W   = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PHASES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PHASE_CYCLES - 1);
  localparam logic [EC_W-1:0]   LOCK_LAST = EC_W'(LOCK_EDGES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t            state, nxt_state;
  logic [SLOT_W-1:0] slot_cnt, nxt_slot;
  logic [IDX_W-1:0]  nxt_idx;
  logic [EC_W-1:0]   edge_cnt, nxt_edge_cnt;
  logic [TO_W-1:0]   to_cnt, nxt_to;
  logic              s1, s2, s3;
  logic              edge_pulse;
  logic              slot_wrap;
  logic [SLOT_W-1:0] slot_adv;
  logic [IDX_W-1:0]  idx_adv;
  logic              nxt_active;
  logic [NUM_PHASES-1:0] nxt_en;

  // s1/s2 resolve metastability on the asynchronous detector output; s3 is history.
  assign edge_pulse = s2 & ~s3;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign slot_adv  = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
  assign idx_adv   = !slot_wrap ? phase_idx :
                     (phase_idx == IDX_LAST) ? '0 : phase_idx + IDX_W'(1);

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    nxt_state    = state;
    nxt_slot     = slot_cnt;
    nxt_idx      = phase_idx;
    nxt_edge_cnt = edge_cnt;
    nxt_to       = to_cnt;

    case (state)
      S_IDLE, S_ERROR: begin
        if (start && !stop) begin
          nxt_state    = S_ACQUIRE;
          nxt_edge_cnt = '0;
          nxt_to       = '0;
        end
      end
      S_ACQUIRE: begin
        if (stop) begin
          nxt_state = S_IDLE;
        end else if (edge_pulse) begin
          nxt_to = '0;
          if (edge_cnt == LOCK_LAST) begin
            nxt_state    = S_RUN;
            nxt_slot     = '0;
            nxt_idx      = '0;
            nxt_edge_cnt = '0;
          end else begin
            nxt_edge_cnt = edge_cnt + EC_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          nxt_state = S_ERROR;
        end else begin
          nxt_to = to_cnt + TO_W'(1);
        end
      end
      S_RUN: begin
        nxt_slot = slot_adv;
        nxt_idx  = idx_adv;
        if (stop) nxt_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (slot_wrap && phase_idx == IDX_LAST) begin
          nxt_state = S_IDLE;
          nxt_slot  = '0;
          nxt_idx   = '0;
        end else begin
          nxt_slot = slot_adv;
          nxt_idx  = idx_adv;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

`ifdef PHASE_RESYNC_EN
    // A detector edge realigns the rotation to phase 0; in DRAIN it also
    // defers completion to the next full pass.
    if ((state == S_RUN || state == S_DRAIN) && edge_pulse) begin
      nxt_slot = '0;
      nxt_idx  = '0;
      if (state == S_DRAIN) nxt_state = S_DRAIN;
    end
`endif
  end

  assign nxt_active = (nxt_state == S_RUN) || (nxt_state == S_DRAIN);
  assign nxt_en     = (nxt_active && nxt_slot != '0)
                      ? (NUM_PHASES'(1) << nxt_idx) : '0;

  // Outputs are computed from next-state values so they are glitch-free flops
  // that line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      slot_cnt  <= '0;
      phase_idx <= '0;
      edge_cnt  <= '0;
      to_cnt    <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      en        <= '0;
      en_bar    <= '1;
      locked    <= 1'b0;
      busy      <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      s1        <= phase_in;
      s2        <= s1;
      s3        <= s2;
      state     <= nxt_state;
      slot_cnt  <= nxt_slot;
      phase_idx <= nxt_idx;
      edge_cnt  <= nxt_edge_cnt;
      to_cnt    <= nxt_to;
      en        <= nxt_en;
      en_bar    <= ~nxt_en;
      locked    <= nxt_active;
      busy      <= (nxt_state != S_IDLE) && (nxt_state != S_ERROR);
      lock_err  <= (nxt_state == S_ERROR);
    end
  end

endmodule
